// File: rtl/pipelined_barrel_shifter_if.sv
// Handshake bundle for the pipelined barrel shifter.
//   in_valid/in_ready  : input word handshake
//   in_data            : operand (WIDTH bits)
//   in_shamt           : shift amount (SW bits, 0..WIDTH-1)
//   in_mode            : 00 LSL, 01 LSR, 10 ASR, 11 ROR
//   out_valid/out_ready: result handshake
//   out_data           : shifted result
//   out_zero           : out_data == 0, qualified by out_valid
// Modports: master drives the inputs and out_ready (upstream/downstream side);
// slave is the shifter's own view.
interface pipelined_barrel_shifter_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SW    = $clog2(WIDTH)
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SW-1:0]    in_shamt;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;

  modport master (
    output in_valid, in_data, in_shamt, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_zero
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_zero
  );
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined logarithmic barrel shifter: SW register stages, stage k shifts by
// 2^k when shift-amount bit k is set. Supports LSL, LSR, ASR and ROR.
// Ports:
//   clk   : sole clock, rising edge
//   rst_n : asynchronous active-low reset, clears every stage
//   bus   : pipelined_barrel_shifter_if.slave (valid/ready in, valid/ready out)
// The whole pipeline advances together when en = out_ready | ~out_valid, so
// bubbles move with valid words and a stalled result is held stable.
module pipelined_barrel_shifter #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SW    = $clog2(WIDTH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  pipelined_barrel_shifter_if.slave  bus
);

  typedef logic [WIDTH-1:0] word_t;
  typedef logic [SW-1:0]    shamt_t;

  typedef enum logic [1:0] {
    MODE_LSL = 2'b00,
    MODE_LSR = 2'b01,
    MODE_ASR = 2'b10,
    MODE_ROR = 2'b11
  } shift_mode_e;

  // One stage's shift by a fixed power-of-two amount (amt < WIDTH).
  function automatic word_t shift_step(word_t d, shift_mode_e mode, logic sign,
                                       int unsigned amt);
    word_t ones;
    word_t res;
    ones = '1;
    case (mode)
      MODE_LSL: res = d << amt;
      MODE_LSR: res = d >> amt;
      // Fill comes from the sign captured at acceptance, not the current MSB.
      MODE_ASR: res = (d >> amt) | (sign ? ~(ones >> amt) : '0);
      MODE_ROR: res = (d >> amt) | (d << (WIDTH - amt));
      default:  res = d;
    endcase
    return res;
  endfunction

  logic [SW-1:0] valid_q, valid_d;
  word_t         data_q  [SW];
  word_t         data_d  [SW];
  // Shift amount is stored pre-shifted so bit 0 is always the next stage's bit.
  shamt_t        shamt_q [SW];
  shamt_t        shamt_d [SW];
  shift_mode_e   mode_q  [SW];
  shift_mode_e   mode_d  [SW];
  logic          sign_q  [SW];
  logic          sign_d  [SW];
  logic          zero_q, zero_d;
  logic          en;

  assign en            = bus.out_ready || !valid_q[SW-1];
  assign bus.in_ready  = en;
  assign bus.out_valid = valid_q[SW-1];
  assign bus.out_data  = data_q[SW-1];
  assign bus.out_zero  = zero_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    shamt_d = shamt_q;
    mode_d  = mode_q;
    sign_d  = sign_q;
    zero_d  = zero_q;
    if (en) begin
      valid_d[0] = bus.in_valid;
      mode_d[0]  = shift_mode_e'(bus.in_mode);
      sign_d[0]  = bus.in_data[WIDTH-1];
      shamt_d[0] = bus.in_shamt >> 1;
      data_d[0]  = bus.in_shamt[0]
                 ? shift_step(bus.in_data, shift_mode_e'(bus.in_mode),
                              bus.in_data[WIDTH-1], 32'd1)
                 : bus.in_data;
      for (int unsigned k = 1; k < SW; k++) begin
        valid_d[k] = valid_q[k-1];
        mode_d[k]  = mode_q[k-1];
        sign_d[k]  = sign_q[k-1];
        shamt_d[k] = shamt_q[k-1] >> 1;
        data_d[k]  = shamt_q[k-1][0]
                   ? shift_step(data_q[k-1], mode_q[k-1], sign_q[k-1], 32'd1 << k)
                   : data_q[k-1];
      end
      zero_d = (data_d[SW-1] == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      zero_q  <= 1'b0;
      for (int unsigned k = 0; k < SW; k++) begin
        data_q[k]  <= '0;
        shamt_q[k] <= '0;
        mode_q[k]  <= MODE_LSL;
        sign_q[k]  <= 1'b0;
      end
    end else begin
      valid_q <= valid_d;
      zero_q  <= zero_d;
      data_q  <= data_d;
      shamt_q <= shamt_d;
      mode_q  <= mode_d;
      sign_q  <= sign_d;
    end
  end

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
module tb_pipelined_barrel_shifter;

  localparam int unsigned WIDTH = 16;
  localparam logic [1:0] LSL = 2'b00;
  localparam logic [1:0] LSR = 2'b01;
  localparam logic [1:0] ASR = 2'b10;
  localparam logic [1:0] ROR = 2'b11;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  pipelined_barrel_shifter_if #(.WIDTH(WIDTH)) bus ();

  pipelined_barrel_shifter #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit-by-bit reference, independent of the stage structure.
  function automatic logic [15:0] ref_shift(logic [15:0] d, logic [3:0] s, logic [1:0] m);
    logic [15:0] r;
    int unsigned si;
    si = s;
    for (int i = 0; i < 16; i++) begin
      case (m)
        LSL: r[i] = (i >= si) ? d[i-si] : 1'b0;
        LSR: r[i] = (i + si < 16) ? d[i+si] : 1'b0;
        ASR: r[i] = (i + si < 16) ? d[i+si] : d[15];
        default: r[i] = d[(i+si)%16];
      endcase
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hFFFF;
    bus.in_shamt = 4'd0;
    bus.in_mode  = LSL;
    bus.out_ready = 1'b0;
    step();
    step();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    n_checks++;
    if (bus.out_data !== 16'h0000) begin n_errors++; $display("FAIL reset_out_data got=%h want=0000", bus.out_data); end
    n_checks++;
    if (bus.out_zero !== 1'b0) begin n_errors++; $display("FAIL reset_out_zero got=%b want=0", bus.out_zero); end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) step();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_no_capture got=%b want=0", bus.out_valid); end
  endtask

  // Offer one word, count edges until out_valid, check latency and result.
  task automatic send_one(input string name, input logic [15:0] d, input logic [3:0] s,
                          input logic [1:0] m, input logic [15:0] exp, input logic exp_zero);
    int edges;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_shamt  = s;
    bus.in_mode   = m;
    step();
    bus.in_valid = 1'b0;
    edges = 1;
    while (!bus.out_valid && edges < 12) begin
      step();
      edges++;
    end
    n_checks++;
    if (edges != 4) begin n_errors++; $display("FAIL %s_latency got=%0d want=4", name, edges); end
    n_checks++;
    if (bus.out_data !== exp) begin n_errors++; $display("FAIL %s_data got=%h want=%h", name, bus.out_data, exp); end
    n_checks++;
    if (bus.out_zero !== exp_zero) begin n_errors++; $display("FAIL %s_zero got=%b want=%b", name, bus.out_zero, exp_zero); end
    step();
  endtask

  task automatic test_modes();
    send_one("lsl15",  16'h0001, 4'd15, LSL, 16'h8000, 1'b0);
    send_one("asr4",   16'h8000, 4'd4,  ASR, 16'hF800, 1'b0);
    send_one("lsr4",   16'h8000, 4'd4,  LSR, 16'h0800, 1'b0);
    send_one("lsl12z", 16'h00F0, 4'd12, LSL, 16'h0000, 1'b1);
    send_one("ror4",   16'h1234, 4'd4,  ROR, 16'h4123, 1'b0);
    send_one("ror0",   16'hABCD, 4'd0,  ROR, 16'hABCD, 1'b0);
    send_one("asrpos", 16'h7000, 4'd4,  ASR, 16'h0700, 1'b0);
    send_one("asr0",   16'h8001, 4'd0,  ASR, 16'h8001, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [15:0] d_tab [8] = '{16'h0003, 16'hF000, 16'h8001, 16'h0001, 16'h1234, 16'h4000, 16'h00FF, 16'hFFFF};
    logic [3:0]  s_tab [8] = '{4'd1, 4'd3, 4'd1, 4'd1, 4'd8, 4'd14, 4'd4, 4'd15};
    logic [1:0]  m_tab [8] = '{LSL, LSR, ASR, ROR, LSL, ASR, ROR, LSR};
    logic [15:0] e_tab [8] = '{16'h0006, 16'h1E00, 16'hC000, 16'h8000, 16'h3400, 16'h0001, 16'hF00F, 16'h0001};
    int sent;
    int recv;
    logic held;
    logic [15:0] held_data;
    sent = 0;
    recv = 0;
    held = 1'b0;
    held_data = '0;
    for (int cyc = 0; cyc < 40 && recv < 8; cyc++) begin
      bus.out_ready = !(cyc >= 6 && cyc <= 8);
      bus.in_valid  = (sent < 8);
      if (sent < 8) begin
        bus.in_data  = d_tab[sent];
        bus.in_shamt = s_tab[sent];
        bus.in_mode  = m_tab[sent];
      end
      #1;
      n_checks++;
      if (bus.in_ready !== !(bus.out_valid && !bus.out_ready)) begin
        n_errors++;
        $display("FAIL b2b_in_ready cyc=%0d got=%b want=%b", cyc, bus.in_ready, !(bus.out_valid && !bus.out_ready));
      end
      if (bus.out_valid && !bus.out_ready) begin
        if (held) begin
          n_checks++;
          if (bus.out_data !== held_data) begin n_errors++; $display("FAIL b2b_stall_stable got=%h want=%h", bus.out_data, held_data); end
        end
        held = 1'b1;
        held_data = bus.out_data;
      end else begin
        held = 1'b0;
      end
      if (bus.out_valid && bus.out_ready) begin
        n_checks++;
        if (bus.out_data !== e_tab[recv]) begin n_errors++; $display("FAIL b2b_data idx=%0d got=%h want=%h", recv, bus.out_data, e_tab[recv]); end
        recv++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    n_checks++;
    if (recv != 8) begin n_errors++; $display("FAIL b2b_count got=%0d want=8", recv); end
    for (int i = 0; i < 6; i++) step();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL b2b_no_dup got=%b want=0", bus.out_valid); end
  endtask

  task automatic test_reset_midflight();
    int stale;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 16'h00F1 + 16'(i);
      bus.in_shamt = 4'd1;
      bus.in_mode  = LSL;
      step();
    end
    bus.in_valid = 1'b0;
    step();
    n_checks++;
    if (bus.out_valid !== 1'b1) begin n_errors++; $display("FAIL midrst_prefill got=%b want=1", bus.out_valid); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL midrst_out_valid got=%b want=0", bus.out_valid); end
    n_checks++;
    if (bus.out_data !== 16'h0000) begin n_errors++; $display("FAIL midrst_out_data got=%h want=0000", bus.out_data); end
    step();
    step();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.out_valid) stale++;
    end
    n_checks++;
    if (stale != 0) begin n_errors++; $display("FAIL midrst_stale got=%0d want=0", stale); end
    send_one("postrst", 16'h0F0F, 4'd4, ROR, 16'hF0F0, 1'b0);
  endtask

  task automatic test_random();
    logic [15:0] exp_q [$];
    logic [15:0] d;
    logic [3:0]  s;
    logic [1:0]  m;
    logic [15:0] e;
    int sent;
    int recv;
    int cyc;
    sent = 0;
    recv = 0;
    cyc = 0;
    while ((sent < 300 || recv < sent) && cyc < 5000) begin
      bus.in_valid  = (sent < 300) && ($urandom_range(3) != 0);
      bus.out_ready = ($urandom_range(3) != 0);
      d = 16'($urandom);
      s = 4'($urandom);
      m = 2'($urandom);
      bus.in_data  = d;
      bus.in_shamt = s;
      bus.in_mode  = m;
      #1;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL rnd_extra got=%h want=none", bus.out_data);
        end else begin
          e = exp_q.pop_front();
          n_checks++;
          if (bus.out_data !== e || bus.out_zero !== (e == 16'h0)) begin
            n_errors++;
            $display("FAIL rnd_data idx=%0d got=%h/%b want=%h/%b", recv, bus.out_data, bus.out_zero, e, (e == 16'h0));
          end
        end
        recv++;
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(ref_shift(d, s, m));
        sent++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    n_checks++;
    if (recv != 300 || exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL rnd_count got=%0d want=300 (left=%0d)", recv, exp_q.size());
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_modes();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
